// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcode constants and format helpers for the decode stage
package id_ex_stage_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Only R, S and B formats carry a real rs2 field.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode != OP_STORE) && (opcode != OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// rtl/id_ex_stage_imm_gen.sv - combinational immediate extraction by opcode format
module imm_gen
  import id_ex_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic s;

  always_comb begin
    s   = instr[31];
    imm = '0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{s}}, instr[31:20]};
      OP_STORE:                 imm = {{20{s}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'b0};
      OP_JAL:                   imm = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage: operand fetch with write-back bypass, load-use bubbles, ID/EX register
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_ID_VALID,
  input  logic [XLEN-1:0]   IF_ID_PC,
  input  logic [31:0]       IF_ID_INSTR,
  output logic [REG_AW-1:0] RS1_ADDR,
  output logic [REG_AW-1:0] RS2_ADDR,
  input  logic [XLEN-1:0]   RF_DATA1,
  input  logic [XLEN-1:0]   RF_DATA2,
  input  logic              WB_WRITE_ENABLE,
  input  logic [REG_AW-1:0] WB_WRITE_ADDRESS,
  input  logic [XLEN-1:0]   WB_WRITE_DATA,
  input  logic              FLUSH,
  input  logic              STALL_IN,
  output logic              STALL_OUT,
  output logic              ID_EX_VALID,
  output logic [XLEN-1:0]   ID_EX_PC,
  output logic [XLEN-1:0]   ID_EX_OP1,
  output logic [XLEN-1:0]   ID_EX_OP2,
  output logic [XLEN-1:0]   ID_EX_IMM,
  output logic [REG_AW-1:0] ID_EX_RD,
  output logic [REG_AW-1:0] ID_EX_RS1,
  output logic [REG_AW-1:0] ID_EX_RS2,
  output logic [6:0]        ID_EX_OPCODE,
  output logic [2:0]        ID_EX_FUNCT3,
  output logic [6:0]        ID_EX_FUNCT7,
  output logic              ID_EX_MEM_READ,
  output logic              ID_EX_REG_WRITE,
  output logic [31:0]       BUBBLE_COUNT
);

  import id_ex_stage_pkg::*;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   op1, op2;
  logic              load_use;

  imm_gen u_imm_gen (
    .instr (IF_ID_INSTR),
    .imm   (imm32)
  );

  always_comb begin
    opcode   = IF_ID_INSTR[6:0];
    rs1      = REG_AW'(IF_ID_INSTR[19:15]);
    rs2      = REG_AW'(IF_ID_INSTR[24:20]);
    rd       = REG_AW'(IF_ID_INSTR[11:7]);
    RS1_ADDR = rs1;
    RS2_ADDR = rs2;
  end

  // The reg_file write in this cycle is not yet visible on RF_DATA, so forward it.
  always_comb begin
    op1 = RF_DATA1;
    op2 = RF_DATA2;
    if (rs1 == '0)
      op1 = '0;
    else if (WB_WRITE_ENABLE && WB_WRITE_ADDRESS == rs1)
      op1 = WB_WRITE_DATA;
    if (rs2 == '0)
      op2 = '0;
    else if (WB_WRITE_ENABLE && WB_WRITE_ADDRESS == rs2)
      op2 = WB_WRITE_DATA;
  end

  always_comb begin
    load_use = ID_EX_VALID && ID_EX_MEM_READ && (ID_EX_RD != '0) && IF_ID_VALID &&
               ((ID_EX_RD == rs1) || (uses_rs2(opcode) && ID_EX_RD == rs2));
    STALL_OUT = (STALL_IN || load_use) && !FLUSH;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ID_EX_VALID     <= 1'b0;
      ID_EX_PC        <= '0;
      ID_EX_OP1       <= '0;
      ID_EX_OP2       <= '0;
      ID_EX_IMM       <= '0;
      ID_EX_RD        <= '0;
      ID_EX_RS1       <= '0;
      ID_EX_RS2       <= '0;
      ID_EX_OPCODE    <= '0;
      ID_EX_FUNCT3    <= '0;
      ID_EX_FUNCT7    <= '0;
      ID_EX_MEM_READ  <= 1'b0;
      ID_EX_REG_WRITE <= 1'b0;
      BUBBLE_COUNT    <= '0;
    end else if (FLUSH) begin
      ID_EX_VALID <= 1'b0;
    end else if (!STALL_IN) begin
      if (load_use) begin
        ID_EX_VALID <= 1'b0;
        if (BUBBLE_COUNT != 32'hFFFF_FFFF)
          BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
      end else begin
        ID_EX_VALID     <= IF_ID_VALID;
        ID_EX_PC        <= IF_ID_PC;
        ID_EX_OP1       <= op1;
        ID_EX_OP2       <= op2;
        ID_EX_IMM       <= XLEN'($signed(imm32));
        ID_EX_RD        <= rd;
        ID_EX_RS1       <= rs1;
        ID_EX_RS2       <= rs2;
        ID_EX_OPCODE    <= opcode;
        ID_EX_FUNCT3    <= IF_ID_INSTR[14:12];
        ID_EX_FUNCT7    <= IF_ID_INSTR[31:25];
        ID_EX_MEM_READ  <= (opcode == OP_LOAD);
        ID_EX_REG_WRITE <= writes_rd(opcode) && (rd != '0);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        CLK;
  logic        RESET;
  logic        IF_ID_VALID;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_INSTR;
  logic [4:0]  RS1_ADDR, RS2_ADDR;
  logic [31:0] RF_DATA1, RF_DATA2;
  logic        WB_WRITE_ENABLE;
  logic [4:0]  WB_WRITE_ADDRESS;
  logic [31:0] WB_WRITE_DATA;
  logic        FLUSH, STALL_IN, STALL_OUT;
  logic        ID_EX_VALID;
  logic [31:0] ID_EX_PC, ID_EX_OP1, ID_EX_OP2, ID_EX_IMM;
  logic [4:0]  ID_EX_RD, ID_EX_RS1, ID_EX_RS2;
  logic [6:0]  ID_EX_OPCODE;
  logic [2:0]  ID_EX_FUNCT3;
  logic [6:0]  ID_EX_FUNCT7;
  logic        ID_EX_MEM_READ, ID_EX_REG_WRITE;
  logic [31:0] BUBBLE_COUNT;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] I_ADD_X3_X0_X2 = 32'h002001B3;
  localparam logic [31:0] I_LW_X5        = 32'h0000A283;
  localparam logic [31:0] I_ADD_X6_X5_X7 = 32'h00728333;
  localparam logic [31:0] I_ADDI_X6_5    = 32'h00500313;
  localparam logic [31:0] I_SW_M4        = 32'hFE20AE23;
  localparam logic [31:0] I_LUI          = 32'h123450B7;
  localparam logic [31:0] I_BEQ_M8       = 32'hFE208CE3;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .IF_ID_VALID      (IF_ID_VALID),
    .IF_ID_PC         (IF_ID_PC),
    .IF_ID_INSTR      (IF_ID_INSTR),
    .RS1_ADDR         (RS1_ADDR),
    .RS2_ADDR         (RS2_ADDR),
    .RF_DATA1         (RF_DATA1),
    .RF_DATA2         (RF_DATA2),
    .WB_WRITE_ENABLE  (WB_WRITE_ENABLE),
    .WB_WRITE_ADDRESS (WB_WRITE_ADDRESS),
    .WB_WRITE_DATA    (WB_WRITE_DATA),
    .FLUSH            (FLUSH),
    .STALL_IN         (STALL_IN),
    .STALL_OUT        (STALL_OUT),
    .ID_EX_VALID      (ID_EX_VALID),
    .ID_EX_PC         (ID_EX_PC),
    .ID_EX_OP1        (ID_EX_OP1),
    .ID_EX_OP2        (ID_EX_OP2),
    .ID_EX_IMM        (ID_EX_IMM),
    .ID_EX_RD         (ID_EX_RD),
    .ID_EX_RS1        (ID_EX_RS1),
    .ID_EX_RS2        (ID_EX_RS2),
    .ID_EX_OPCODE     (ID_EX_OPCODE),
    .ID_EX_FUNCT3     (ID_EX_FUNCT3),
    .ID_EX_FUNCT7     (ID_EX_FUNCT7),
    .ID_EX_MEM_READ   (ID_EX_MEM_READ),
    .ID_EX_REG_WRITE  (ID_EX_REG_WRITE),
    .BUBBLE_COUNT     (BUBBLE_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; IF_ID_VALID = 1'b0; IF_ID_PC = '0; IF_ID_INSTR = '0;
    RF_DATA1 = '0; RF_DATA2 = '0; WB_WRITE_ENABLE = 1'b0; WB_WRITE_ADDRESS = '0;
    WB_WRITE_DATA = '0; FLUSH = 1'b0; STALL_IN = 1'b0;

    // asynchronous reset before the first posedge
    #1 RESET = 1'b0;
    #1;
    check("reset_valid", {31'b0, ID_EX_VALID}, 32'd0);
    check("reset_pc", ID_EX_PC, 32'd0);
    check("reset_op1", ID_EX_OP1, 32'd0);
    check("reset_regwrite", {31'b0, ID_EX_REG_WRITE}, 32'd0);
    check("reset_bubbles", BUBBLE_COUNT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // bypass from write-back
    IF_ID_VALID = 1'b1; IF_ID_PC = 32'h100; IF_ID_INSTR = I_ADD_X3_X1_X2;
    RF_DATA1 = 32'd5; RF_DATA2 = 32'd7;
    WB_WRITE_ENABLE = 1'b1; WB_WRITE_ADDRESS = 5'd1; WB_WRITE_DATA = 32'd10;
    #1;
    check("rs1_addr", {27'b0, RS1_ADDR}, 32'd1);
    check("rs2_addr", {27'b0, RS2_ADDR}, 32'd2);
    step();
    check("byp_valid", {31'b0, ID_EX_VALID}, 32'd1);
    check("byp_pc", ID_EX_PC, 32'h100);
    check("byp_op1", ID_EX_OP1, 32'd10);
    check("byp_op2", ID_EX_OP2, 32'd7);
    check("byp_rd", {27'b0, ID_EX_RD}, 32'd3);
    check("byp_opcode", {25'b0, ID_EX_OPCODE}, 32'h33);
    check("byp_imm", ID_EX_IMM, 32'd0);
    check("byp_regwrite", {31'b0, ID_EX_REG_WRITE}, 32'd1);

    // write to x0 must not bypass
    IF_ID_PC = 32'h104; IF_ID_INSTR = I_ADD_X3_X0_X2; WB_WRITE_ADDRESS = 5'd0;
    step();
    check("x0_op1", ID_EX_OP1, 32'd0);
    WB_WRITE_ENABLE = 1'b0;

    // load-use: one bubble then capture
    IF_ID_PC = 32'h108; IF_ID_INSTR = I_LW_X5; RF_DATA1 = 32'h20;
    step();
    check("lw_memread", {31'b0, ID_EX_MEM_READ}, 32'd1);
    check("lw_rd", {27'b0, ID_EX_RD}, 32'd5);
    IF_ID_PC = 32'h10C; IF_ID_INSTR = I_ADD_X6_X5_X7;
    #1;
    check("lu_stall_out", {31'b0, STALL_OUT}, 32'd1);
    step();
    check("lu_bubble_valid", {31'b0, ID_EX_VALID}, 32'd0);
    check("lu_count", BUBBLE_COUNT, 32'd1);
    check("lu_stall_clear", {31'b0, STALL_OUT}, 32'd0);
    step();
    check("lu_dep_valid", {31'b0, ID_EX_VALID}, 32'd1);
    check("lu_dep_pc", ID_EX_PC, 32'h10C);
    check("lu_dep_rd", {27'b0, ID_EX_RD}, 32'd6);
    check("lu_count_hold", BUBBLE_COUNT, 32'd1);

    // I-type whose imm bits alias rs2 = x5: no hazard
    IF_ID_PC = 32'h110; IF_ID_INSTR = I_LW_X5;
    step();
    IF_ID_PC = 32'h114; IF_ID_INSTR = I_ADDI_X6_5;
    #1;
    check("itype_no_stall", {31'b0, STALL_OUT}, 32'd0);
    step();
    check("itype_valid", {31'b0, ID_EX_VALID}, 32'd1);
    check("itype_imm", ID_EX_IMM, 32'd5);
    check("itype_count", BUBBLE_COUNT, 32'd1);

    // flush wins over load-use
    IF_ID_PC = 32'h118; IF_ID_INSTR = I_LW_X5;
    step();
    IF_ID_PC = 32'h11C; IF_ID_INSTR = I_ADD_X6_X5_X7; FLUSH = 1'b1;
    #1;
    check("flush_stall_out", {31'b0, STALL_OUT}, 32'd0);
    step();
    check("flush_valid", {31'b0, ID_EX_VALID}, 32'd0);
    check("flush_count", BUBBLE_COUNT, 32'd1);
    FLUSH = 1'b0;

    // store immediate, then hold under STALL_IN
    IF_ID_PC = 32'h200; IF_ID_INSTR = I_SW_M4;
    step();
    check("sw_imm", ID_EX_IMM, 32'hFFFF_FFFC);
    check("sw_regwrite", {31'b0, ID_EX_REG_WRITE}, 32'd0);
    IF_ID_PC = 32'h204; IF_ID_INSTR = I_LUI; STALL_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", ID_EX_PC, 32'h200);
      check("stall_imm", ID_EX_IMM, 32'hFFFF_FFFC);
      check("stall_out", {31'b0, STALL_OUT}, 32'd1);
    end
    STALL_IN = 1'b0;
    step();
    check("lui_pc", ID_EX_PC, 32'h204);
    check("lui_imm", ID_EX_IMM, 32'h1234_5000);
    check("lui_rd", {27'b0, ID_EX_RD}, 32'd1);
    check("lui_regwrite", {31'b0, ID_EX_REG_WRITE}, 32'd1);

    IF_ID_PC = 32'h208; IF_ID_INSTR = I_BEQ_M8;
    step();
    check("beq_imm", ID_EX_IMM, 32'hFFFF_FFF8);
    check("beq_regwrite", {31'b0, ID_EX_REG_WRITE}, 32'd0);

    // reset during a stall drops the held instruction
    STALL_IN = 1'b1;
    step();
    #2 RESET = 1'b0;
    #1;
    check("rst_stall_valid", {31'b0, ID_EX_VALID}, 32'd0);
    check("rst_stall_pc", ID_EX_PC, 32'd0);
    check("rst_stall_count", BUBBLE_COUNT, 32'd0);
    RESET = 1'b1;
    STALL_IN = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
